sudoku_board_ctrl: RTL

- Parametrised game-board controller for the sudoku design; replaces the fixed 9x9 board logic with a grid of BOX*BOX by BOX*BOX cells.
- Loads a packed puzzle, tracks a cursor driven by the pad buttons, and edits non-fixed cells.
- Tracks the filled-cell count and flags a completed board.
- Sits between button inputs and the display/render logic, which consumes the packed board output.

---
 rtl/sudoku_pkg.sv | 34 +++
 rtl/sudoku_button_edge.sv | 27 ++
 rtl/sudoku_board_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/sudoku_pkg.sv
// Shared types, default geometry and index helpers for the sudoku board controller.
package sudoku_pkg;

    localparam int unsigned BOX_DEF    = 3;
    localparam int unsigned SIDE_DEF   = BOX_DEF * BOX_DEF;
    localparam int unsigned CELLS_DEF  = SIDE_DEF * SIDE_DEF;
    localparam int unsigned VAL_W_DEF  = $clog2(SIDE_DEF + 1);
    localparam int unsigned CELL_W_DEF = VAL_W_DEF + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } game_state_e;

    function automatic int unsigned cell_index(input int unsigned row,
                                               input int unsigned col,
                                               input int unsigned side);
        return row * side + col;
    endfunction

    // Flat index of the k-th cell (row-major) inside box number 'box'.
    function automatic int unsigned box_index(input int unsigned box,
                                              input int unsigned k,
                                              input int unsigned bx);
        int unsigned br;
        int unsigned bc;
        br = (box / bx) * bx + k / bx;
        bc = (box % bx) * bx + k % bx;
        return cell_index(br, bc, bx * bx);
    endfunction

endpackage

// File: rtl/sudoku_button_edge.sv
// Registered rising-edge detector; pulse_o is combinational and one-hot, bit 0 highest priority.
module sudoku_button_edge #(
    parameter int unsigned W = 7
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] btn_i,
    output logic [W-1:0] pulse_o
);

    logic [W-1:0] prev_q;
    logic [W-1:0] rise;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_q <= '0;
        end else begin
            prev_q <= btn_i;
        end
    end

    assign rise = btn_i & ~prev_q;

    // Two's-complement trick isolates the lowest set bit.
    assign pulse_o = rise & (~rise + W'(1));

endmodule

// File: rtl/sudoku_board_ctrl.sv
// Sudoku board controller: puzzle load, cursor, cell edits, fill count, completion.
// Optional conflict scan enabled by defining SUDOKU_CONFLICT_CHECK_EN.
module sudoku_board_ctrl
    import sudoku_pkg::*;
#(
    parameter int unsigned BOX = BOX_DEF
) (
    input  logic                                                        clk,
    input  logic                                                        reset,
    input  logic                                                        up_button,
    input  logic                                                        down_button,
    input  logic                                                        left_button,
    input  logic                                                        right_button,
    input  logic                                                        start_button,
    input  logic                                                        a_button,
    input  logic                                                        b_button,
    input  logic [(BOX*BOX)*(BOX*BOX)*($clog2(BOX*BOX+1)+1)-1:0]       initial_board,
    output logic [(BOX*BOX)*(BOX*BOX)*($clog2(BOX*BOX+1)+1)-1:0]       board,
    output logic [$clog2(BOX*BOX)-1:0]                                  cursor_row,
    output logic [$clog2(BOX*BOX)-1:0]                                  cursor_col,
    output logic [1:0]                                                  game_state,
    output logic [$clog2((BOX*BOX)*(BOX*BOX)+1)-1:0]                    filled_count,
    output logic                                                        conflict
);

    localparam int unsigned SIDE   = BOX * BOX;
    localparam int unsigned CELLS  = SIDE * SIDE;
    localparam int unsigned VAL_W  = $clog2(SIDE + 1);
    localparam int unsigned CELL_W = VAL_W + 1;
    localparam int unsigned POS_W  = $clog2(SIDE);
    localparam int unsigned CNT_W  = $clog2(CELLS + 1);
    localparam int unsigned BRD_W  = CELLS * CELL_W;

    game_state_e       state_q, state_d;
    logic [BRD_W-1:0]  board_q, board_d, load_board;
    logic [POS_W-1:0]  row_q, row_d, col_q, col_d;
    logic [CNT_W-1:0]  filled_q, filled_d, load_cnt, cur_idx;
    logic              conflict_q, conflict_d;
    logic [6:0]        btn, pulse;
    logic [CELL_W-1:0] cur_cell;
    logic [VAL_W-1:0]  cur_val, inc_val;
    logic              cur_fixed, play, do_a, do_b, full_after_a;

    // Bit order sets action priority: start, b, a, up, down, left, right.
    assign btn = {right_button, left_button, down_button, up_button,
                  a_button, b_button, start_button};

    sudoku_button_edge #(.W(7)) u_edge (
        .clk_i  (clk),
        .rst_i  (reset),
        .btn_i  (btn),
        .pulse_o(pulse)
    );

    assign cur_idx      = CNT_W'(cell_index(32'(row_q), 32'(col_q), SIDE));
    assign cur_cell     = board_q[cur_idx*CELL_W +: CELL_W];
    assign cur_val      = cur_cell[VAL_W-1:0];
    assign cur_fixed    = cur_cell[CELL_W-1];
    assign inc_val      = (cur_val == VAL_W'(SIDE)) ? VAL_W'(1) : cur_val + VAL_W'(1);
    assign play         = (state_q == ST_PLAY);
    assign do_a         = play & pulse[2] & ~cur_fixed;
    assign do_b         = play & pulse[1] & ~cur_fixed;
    assign full_after_a = (filled_q + CNT_W'(cur_val == '0)) == CNT_W'(CELLS);

    // Puzzle sanitising: out-of-range values load as empty, nonzero cells become fixed.
    always_comb begin
        load_board = '0;
        load_cnt   = '0;
        for (int unsigned i = 0; i < CELLS; i++) begin
            if (initial_board[i*CELL_W +: VAL_W] != '0 &&
                initial_board[i*CELL_W +: VAL_W] <= VAL_W'(SIDE)) begin
                load_board[i*CELL_W +: CELL_W] = {1'b1, initial_board[i*CELL_W +: VAL_W]};
                load_cnt = load_cnt + CNT_W'(1);
            end
        end
    end

`ifdef SUDOKU_CONFLICT_CHECK_EN
    logic [POS_W-1:0] k_q, k_d;
    logic             match_q, match_d, hit, match_fin;
    int unsigned      r_idx, c_idx, b_idx, bnum;

    // One scan step: row cell k, column cell k and box cell k against the written value.
    always_comb begin
        bnum  = (32'(row_q) / BOX) * BOX + 32'(col_q) / BOX;
        r_idx = cell_index(32'(row_q), 32'(k_q), SIDE);
        c_idx = cell_index(32'(k_q), 32'(col_q), SIDE);
        b_idx = box_index(bnum, 32'(k_q), BOX);
        hit   = ((k_q != col_q) && (board_q[r_idx*CELL_W +: VAL_W] == cur_val)) ||
                ((k_q != row_q) && (board_q[c_idx*CELL_W +: VAL_W] == cur_val)) ||
                ((b_idx != 32'(cur_idx)) && (board_q[b_idx*CELL_W +: VAL_W] == cur_val));
    end

    assign match_fin = match_q | hit;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (pulse[0]) begin
            state_d = ST_PLAY;
        end else begin
            case (state_q)
                ST_PLAY: begin
`ifdef SUDOKU_CONFLICT_CHECK_EN
                    if (do_a) state_d = ST_CHECK;
`else
                    if (do_a && full_after_a) state_d = ST_DONE;
`endif
                end
`ifdef SUDOKU_CONFLICT_CHECK_EN
                ST_CHECK: begin
                    if (k_q == POS_W'(SIDE - 1)) begin
                        state_d = (filled_q == CNT_W'(CELLS) && !match_fin) ? ST_DONE : ST_PLAY;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_comb begin
        board_d    = board_q;
        row_d      = row_q;
        col_d      = col_q;
        filled_d   = filled_q;
        conflict_d = conflict_q;
`ifdef SUDOKU_CONFLICT_CHECK_EN
        k_d        = k_q;
        match_d    = match_q;
`endif
        if (pulse[0]) begin
            board_d    = load_board;
            filled_d   = load_cnt;
            row_d      = '0;
            col_d      = '0;
            conflict_d = 1'b0;
`ifdef SUDOKU_CONFLICT_CHECK_EN
            k_d        = '0;
            match_d    = 1'b0;
`endif
        end else if (play) begin
            if (do_b) begin
                board_d[cur_idx*CELL_W +: VAL_W] = '0;
                if (cur_val != '0) filled_d = filled_q - CNT_W'(1);
                conflict_d = 1'b0;
            end else if (do_a) begin
                board_d[cur_idx*CELL_W +: VAL_W] = inc_val;
                if (cur_val == '0) filled_d = filled_q + CNT_W'(1);
`ifdef SUDOKU_CONFLICT_CHECK_EN
                k_d     = '0;
                match_d = 1'b0;
`endif
            end else if (pulse[3]) begin
                row_d = (row_q == '0) ? POS_W'(SIDE - 1) : row_q - POS_W'(1);
            end else if (pulse[4]) begin
                row_d = (row_q == POS_W'(SIDE - 1)) ? '0 : row_q + POS_W'(1);
            end else if (pulse[5]) begin
                col_d = (col_q == '0) ? POS_W'(SIDE - 1) : col_q - POS_W'(1);
            end else if (pulse[6]) begin
                col_d = (col_q == POS_W'(SIDE - 1)) ? '0 : col_q + POS_W'(1);
            end
        end
`ifdef SUDOKU_CONFLICT_CHECK_EN
        else if (state_q == ST_CHECK) begin
            k_d     = k_q + POS_W'(1);
            match_d = match_fin;
            if (k_q == POS_W'(SIDE - 1)) conflict_d = match_fin;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            board_q    <= '0;
            row_q      <= '0;
            col_q      <= '0;
            filled_q   <= '0;
            conflict_q <= 1'b0;
`ifdef SUDOKU_CONFLICT_CHECK_EN
            k_q        <= '0;
            match_q    <= 1'b0;
`endif
        end else begin
            board_q    <= board_d;
            row_q      <= row_d;
            col_q      <= col_d;
            filled_q   <= filled_d;
            conflict_q <= conflict_d;
`ifdef SUDOKU_CONFLICT_CHECK_EN
            k_q        <= k_d;
            match_q    <= match_d;
`endif
        end
    end

    assign board        = board_q;
    assign cursor_row   = row_q;
    assign cursor_col   = col_q;
    assign game_state   = state_q;
    assign filled_count = filled_q;
    assign conflict     = conflict_q;

endmodule
